sclk_divider: RTL

- Counterpart to the PLL stage: the PLL multiplies the board clock up to the 100 MHz global clock, and this block divides that clock back down.
- Generates a 50%-duty divided clock (`clk_out`) plus single-cycle rise/fall strobes, used as SCLK and sampling enables for the RHS serial interface.
- The half-period is runtime-programmable. A new divisor is applied only on a period boundary and is acknowledged, so `clk_out` never glitches.

---
 rtl/sclk_divider_if.sv | 36 +++
 rtl/sclk_divider.sv | 118 +++++++++++
 2 files changed

// File: rtl/sclk_divider_if.sv
// Divided-clock control and status bundle shared by the
// SCLK divider and whatever programs or consumes it.
interface sclk_divider_if #(
    parameter int DIV_W = 8
);
    logic             enable;
    logic [DIV_W-1:0] div_half;
    logic             div_load;
    logic             div_ack;
    logic             clk_out;
    logic             rise_stb;
    logic             fall_stb;
    logic             busy;

    modport master (
        output enable,
        output div_half,
        output div_load,
        input  div_ack,
        input  clk_out,
        input  rise_stb,
        input  fall_stb,
        input  busy
    );

    modport slave (
        input  enable,
        input  div_half,
        input  div_load,
        output div_ack,
        output clk_out,
        output rise_stb,
        output fall_stb,
        output busy
    );
endinterface

// File: rtl/sclk_divider.sv
// Glitch-free programmable divider for the serial-interface SCLK;
// divisor changes take effect only on a period boundary.
module sclk_divider #(
    parameter int DIV_W        = 8,
    parameter int DEFAULT_HALF = 2
) (
    input logic           clock_in,
    input logic           reset,
    sclk_divider_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    localparam logic [DIV_W-1:0] DEF_HALF = DIV_W'(DEFAULT_HALF);
    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);

    state_t           state_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] half_q;
    logic [DIV_W-1:0] pend_q;
    logic             pend_vld_q;
    logic             clk_q;
    logic             rise_q;
    logic             fall_q;
    logic             ack_q;
    logic             busy_q;

    logic [DIV_W-1:0] half_act;
    logic             at_last;

    // A programmed zero behaves as the fastest legal setting.
    assign half_act = (half_q == '0) ? ONE : half_q;
    assign at_last  = (cnt_q == half_act - ONE);

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            half_q     <= DEF_HALF;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            clk_q      <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            ack_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pend_vld_q) begin
                        half_q     <= pend_q;
                        ack_q      <= 1'b1;
                        pend_vld_q <= 1'b0;
                    end
                    if (bus.enable) begin
                        clk_q   <= 1'b1;
                        rise_q  <= 1'b1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= HIGH;
                    end
                end
                HIGH: begin
                    if (at_last) begin
                        clk_q   <= 1'b0;
                        fall_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= LOW;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                LOW: begin
                    if (!at_last) begin
                        cnt_q <= cnt_q + ONE;
                    end else if (bus.enable) begin
                        if (pend_vld_q) begin
                            half_q     <= pend_q;
                            ack_q      <= 1'b1;
                            pend_vld_q <= 1'b0;
                        end
                        clk_q   <= 1'b1;
                        rise_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= HIGH;
                    end else begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    clk_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
            // Placed last so a load in the apply cycle keeps pending set.
            if (bus.div_load) begin
                pend_q     <= bus.div_half;
                pend_vld_q <= 1'b1;
            end
        end
    end

    assign bus.clk_out  = clk_q;
    assign bus.rise_stb = rise_q;
    assign bus.fall_stb = fall_q;
    assign bus.div_ack  = ack_q;
    assign bus.busy     = busy_q;
endmodule
